sa_wb_data_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L1 data cache sitting between the core's load/store port and the memory arbiter. It generalises the 2-way write-through data cache to configurable ways, sets, line and word size. It keeps per-line dirty state, evicts dirty victims with a burst write before refilling, and picks victims per set (invalid way first, otherwise round-robin). Tag, state and data are held in flop arrays with single-cycle lookup, so no SRAM wait counter is needed.

---
 rtl/sa_wb_data_cache.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_sa_wb_data_cache.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wb_data_cache.sv
// sa_wb_data_cache: N-way set-associative, write-back, write-allocate L1 data
// cache. Tags, state and data live in flop arrays, so a lookup takes a single
// cycle. Misses evict a dirty victim with a burst of write beats and then
// refill the line. Stores are merged by replaying the lookup after the fill.
module sa_wb_data_cache #(
  parameter int ADDR_W   = 64,
  parameter int WORD_W   = 64,
  parameter int WAYS     = 2,
  parameter int LOG_SETS = 6,
  parameter int LOG_LINE = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  // core load/store port
  input  logic              core_reqcyc,
  output logic              core_reqack,
  input  logic [ADDR_W-1:0] core_req,
  input  logic              core_we,
  input  logic [WORD_W-1:0] core_wdata,
  output logic              core_respcyc,
  output logic [WORD_W-1:0] core_resp,
  input  logic              core_respack,
  // memory arbiter port
  output logic              mem_reqcyc,
  input  logic              mem_reqack,
  output logic [ADDR_W-1:0] mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_respcyc,
  input  logic [WORD_W-1:0] mem_resp,
  output logic              mem_respack
);

  localparam int WB      = $clog2(WORD_W / 8);
  localparam int LOG_WPL = LOG_LINE - WB;
  localparam int WPL     = 1 << LOG_WPL;
  localparam int SETS    = 1 << LOG_SETS;
  localparam int TAG_W   = ADDR_W - LOG_SETS - LOG_LINE;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W  = (LOG_WPL > 0) ? LOG_WPL : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL_REQ,
    S_FILL,
    S_RESP
  } state_t;

  // Storage arrays
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WORD_W-1:0] data_q  [SETS][WAYS][WPL];

  // Control registers
  state_t              state_q, state_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [LOG_SETS-1:0] req_set_q, req_set_d;
  logic [BEAT_W-1:0]   req_word_q, req_word_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                reqack_q, reqack_d;
  logic                respcyc_q, respcyc_d;
  logic [WORD_W-1:0]   resp_q, resp_d;

  // Array write controls
  logic [WAY_W-1:0]    meta_way;
  logic [BEAT_W-1:0]   data_word;
  logic [WORD_W-1:0]   data_wval;
  logic                data_we;
  logic                tag_we;
  logic                v_set, v_clr, d_set, d_clr, rr_we;

  // Lookup results
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic                victim_dirty;

  // Sub-word byte offset bits of the core address carry no information.
  logic unused_low;
  assign unused_low = ^core_req[WB-1:0];

  assign core_reqack  = reqack_q;
  assign core_respcyc = respcyc_q;
  assign core_resp    = resp_q;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]    t,
                                                  input logic [LOG_SETS-1:0] s);
    return {t, s, {LOG_LINE{1'b0}}};
  endfunction

  function automatic logic [ADDR_W-1:0] beat_offset(input logic [BEAT_W-1:0] b);
    return ADDR_W'(b) << WB;
  endfunction

  function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
    // WAYS is a power of two, so the natural WAY_W-bit wrap is the modulo.
    return (WAYS == 1) ? '0 : w + 1'b1;
  endfunction

  // Tag compare across all ways of the latched set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set_q][w] && (tag_q[req_set_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, otherwise the set's rr pointer
  always_comb begin
    victim = rr_q[req_set_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set_q][w]) victim = WAY_W'(w);
    end
    victim_dirty = valid_q[req_set_q][victim] && dirty_q[req_set_q][victim];
  end

  // Next-state, handshake outputs and array write controls
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_set_d   = req_set_q;
    req_word_d  = req_word_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    reqack_d    = 1'b0;
    respcyc_d   = respcyc_q;
    resp_d      = resp_q;
    mem_reqcyc  = 1'b0;
    mem_we      = 1'b0;
    mem_req     = '0;
    mem_wdata   = '0;
    mem_respack = 1'b0;
    meta_way    = victim_q;
    data_word   = beat_q;
    data_wval   = mem_resp;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    v_set       = 1'b0;
    v_clr       = 1'b0;
    d_set       = 1'b0;
    d_clr       = 1'b0;
    rr_we       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (core_reqcyc) begin
          req_tag_d  = core_req[ADDR_W-1 -: TAG_W];
          req_set_d  = core_req[LOG_LINE +: LOG_SETS];
          req_word_d = core_req[WB +: BEAT_W];
          we_d       = core_we;
          wdata_d    = core_wdata;
          reqack_d   = 1'b1;
          state_d    = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          respcyc_d = 1'b1;
          state_d   = S_RESP;
          meta_way  = hit_way;
          if (we_q) begin
            data_word = req_word_q;
            data_wval = wdata_q;
            data_we   = 1'b1;
            d_set     = 1'b1;
          end else begin
            resp_d = data_q[req_set_q][hit_way][req_word_q];
          end
        end else begin
          // The victim loses its valid bit now so a partial refill is never
          // mistaken for a resident line; its tag/data stay for the eviction.
          victim_d = victim;
          meta_way = victim;
          v_clr    = 1'b1;
          beat_d   = '0;
          state_d  = victim_dirty ? S_EVICT : S_FILL_REQ;
        end
      end

      S_EVICT: begin
        mem_reqcyc = 1'b1;
        mem_we     = 1'b1;
        mem_req    = line_addr(tag_q[req_set_q][victim_q], req_set_q) | beat_offset(beat_q);
        mem_wdata  = data_q[req_set_q][victim_q][beat_q];
        if (mem_reqack) begin
          if (beat_q == BEAT_W'(WPL - 1)) begin
            d_clr   = 1'b1;
            beat_d  = '0;
            state_d = S_FILL_REQ;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_FILL_REQ: begin
        mem_reqcyc = 1'b1;
        mem_req    = line_addr(req_tag_q, req_set_q);
        if (mem_reqack) begin
          beat_d  = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        mem_respack = mem_respcyc;
        if (mem_respcyc) begin
          data_we = 1'b1;
          if (beat_q == BEAT_W'(WPL - 1)) begin
            tag_we  = 1'b1;
            v_set   = 1'b1;
            d_clr   = 1'b1;
            rr_we   = 1'b1;
            beat_d  = '0;
            state_d = S_LOOKUP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_RESP: begin
        if (core_respack) begin
          respcyc_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_tag_q  <= '0;
      req_set_q  <= '0;
      req_word_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      reqack_q   <= 1'b0;
      respcyc_q  <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_tag_q  <= req_tag_d;
      req_set_q  <= req_set_d;
      req_word_q <= req_word_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      victim_q   <= victim_d;
      beat_q     <= beat_d;
      reqack_q   <= reqack_d;
      respcyc_q  <= respcyc_d;
      resp_q     <= resp_d;
    end
  end

  // Per-line valid/dirty bits and per-set replacement pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (v_clr) valid_q[req_set_q][meta_way] <= 1'b0;
      if (v_set) valid_q[req_set_q][meta_way] <= 1'b1;
      if (d_set) dirty_q[req_set_q][meta_way] <= 1'b1;
      if (d_clr) dirty_q[req_set_q][meta_way] <= 1'b0;
      if (rr_we) rr_q[req_set_q] <= next_way(meta_way);
    end
  end

  // Tag and data arrays (contents are meaningless until valid is set)
  always_ff @(posedge clk) begin
    if (data_we) data_q[req_set_q][meta_way][data_word] <= data_wval;
    if (tag_we)  tag_q[req_set_q][meta_way] <= req_tag_q;
  end

endmodule

// File: tb/tb_sa_wb_data_cache.sv
// Bench for sa_wb_data_cache (2 ways, 64 sets, 64-byte lines, 64-bit words).
// A behavioural memory serves fills and absorbs write beats; a table of core
// accesses is replayed with expected data queued on a scoreboard.
module tb_sa_wb_data_cache;

  localparam int WPL = 8;

  logic        clk;
  logic        reset_n;
  logic        core_reqcyc;
  logic        core_reqack;
  logic [63:0] core_req;
  logic        core_we;
  logic [63:0] core_wdata;
  logic        core_respcyc;
  logic [63:0] core_resp;
  logic        core_respack;
  logic        mem_reqcyc;
  logic        mem_reqack;
  logic [63:0] mem_req;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic        mem_respcyc;
  logic [63:0] mem_resp;
  logic        mem_respack;

  sa_wb_data_cache #(
    .ADDR_W(64), .WORD_W(64), .WAYS(2), .LOG_SETS(6), .LOG_LINE(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_reqcyc(core_reqcyc), .core_reqack(core_reqack), .core_req(core_req),
    .core_we(core_we), .core_wdata(core_wdata), .core_respcyc(core_respcyc),
    .core_resp(core_resp), .core_respack(core_respack),
    .mem_reqcyc(mem_reqcyc), .mem_reqack(mem_reqack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_respcyc(mem_respcyc),
    .mem_resp(mem_resp), .mem_respack(mem_respack)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] exp;    // expected load data
    int          fills;  // fill requests caused by this access
    int          wbs;    // write beats caused by this access
    int          lat;    // cycles from request to response, 0 = unchecked
    bit          early;  // core_respack already high when response rises
    bit          thr;    // arbiter acks only every 3rd cycle
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] fill_q[$];
  logic [63:0] wb_addr_q[$];
  logic [63:0] wb_data_q[$];
  logic [63:0] mem [logic [63:0]];
  bit          throttle = 0;
  int          fill_idx = 0;
  int          beats_left = 0;
  logic [63:0] fill_base = '0;
  int          cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Untouched memory reads back ((addr>>12)<<4) + word index, e.g. 0x1008 -> 0x11.
  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return ((a >> 12) << 4) + ((a >> 3) & 64'h7);
  endfunction

  // Memory/arbiter model: drives on the falling edge, DUT samples on the rising edge
  initial begin
    mem_reqack  = 1'b0;
    mem_respcyc = 1'b0;
    mem_resp    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_reqack = 1'b0;
      if (!reset_n) begin
        beats_left  = 0;
        mem_respcyc = 1'b0;
      end else begin
        if (beats_left > 0) begin
          mem_respcyc = 1'b1;
          mem_resp    = mem_rd(fill_base + 64'(fill_idx) * 8);
          fill_idx++;
          beats_left--;
        end else begin
          mem_respcyc = 1'b0;
        end
        if (mem_reqcyc && (!throttle || (cyc % 3 == 0))) begin
          mem_reqack = 1'b1;
          if (mem_we) begin
            wb_addr_q.push_back(mem_req);
            wb_data_q.push_back(mem_wdata);
            mem[mem_req] = mem_wdata;
          end else begin
            fill_q.push_back(mem_req);
            fill_base  = mem_req;
            fill_idx   = 0;
            beats_left = WPL;
          end
        end
      end
    end
  end

  task automatic access(input vec_t v);
    int          lat;
    int          acks;
    int          f0;
    int          w0;
    bit          done;
    logic [63:0] exp;
    f0 = fill_q.size();
    w0 = wb_addr_q.size();
    throttle = v.thr;
    @(negedge clk);
    core_reqcyc  = 1'b1;
    core_req     = v.addr;
    core_we      = v.we;
    core_wdata   = v.wdata;
    core_respack = v.early;
    exp_q.push_back(v.exp);
    lat  = 0;
    acks = 0;
    done = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (core_reqack) begin
        acks++;
        core_reqcyc = 1'b0;
      end
      if (core_respcyc) done = 1;
    end
    check("resp_arrived", 64'(done), 64'd1);
    exp = exp_q.pop_front();
    check("reqack_pulse_count", 64'(acks), 64'd1);
    if (!v.we) check("load_data", core_resp, exp);
    if (v.lat != 0) check("latency", 64'(lat), 64'(v.lat));
    check("fill_requests", 64'(fill_q.size() - f0), 64'(v.fills));
    check("write_beats", 64'(wb_addr_q.size() - w0), 64'(v.wbs));
    if (v.fills == 1 && fill_q.size() > f0)
      check("fill_addr", fill_q[f0], v.addr & ~64'h3f);
    if (v.early) begin
      @(posedge clk);
      #1;
      check("resp_single_cycle", 64'(core_respcyc), 64'd0);
      core_respack = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      check("resp_held", 64'(core_respcyc), 64'd1);
      if (!v.we) check("resp_data_held", core_resp, exp);
      core_respack = 1'b1;
      @(posedge clk);
      #1;
      check("resp_released", 64'(core_respcyc), 64'd0);
      core_respack = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs [12];
    vec_t rv;
    int   w0;
    bit   hit4;

    //            addr       we    wdata      exp       f  w  lat early thr
    vecs[0]  = '{64'h1008, 1'b0, 64'h0,    64'h11,   1, 0, 12, 0, 0};
    vecs[1]  = '{64'h1008, 1'b0, 64'h0,    64'h11,   0, 0, 2,  1, 0};
    vecs[2]  = '{64'h1010, 1'b1, 64'hAAAA, 64'h0,    0, 0, 2,  0, 0};
    vecs[3]  = '{64'h1010, 1'b0, 64'h0,    64'hAAAA, 0, 0, 2,  0, 0};
    vecs[4]  = '{64'h2000, 1'b0, 64'h0,    64'h20,   1, 0, 12, 0, 0};
    vecs[5]  = '{64'h3000, 1'b0, 64'h0,    64'h30,   1, 8, 20, 0, 0};
    vecs[6]  = '{64'h1010, 1'b0, 64'h0,    64'hAAAA, 1, 0, 12, 0, 0};
    vecs[7]  = '{64'h5018, 1'b1, 64'h1234, 64'h0,    1, 0, 12, 0, 0};
    vecs[8]  = '{64'h5018, 1'b0, 64'h0,    64'h1234, 0, 0, 2,  1, 0};
    vecs[9]  = '{64'h5010, 1'b0, 64'h0,    64'h52,   0, 0, 2,  0, 0};
    vecs[10] = '{64'h6000, 1'b0, 64'h0,    64'h60,   1, 0, 12, 0, 0};
    vecs[11] = '{64'h7000, 1'b0, 64'h0,    64'h70,   1, 8, 0,  0, 1};

    reset_n      = 1'b0;
    core_reqcyc  = 1'b0;
    core_req     = '0;
    core_we      = 1'b0;
    core_wdata   = '0;
    core_respack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reqack", 64'(core_reqack), 64'd0);
    check("rst_core_respcyc", 64'(core_respcyc), 64'd0);
    check("rst_core_resp", core_resp, 64'd0);
    check("rst_mem_reqcyc", 64'(mem_reqcyc), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_req", mem_req, 64'd0);
    check("rst_mem_respack", 64'(mem_respack), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      w0 = wb_addr_q.size();
      access(vecs[i]);
      if (i == 5) begin
        for (int b = 0; b < WPL; b++) begin
          if (w0 + b < wb_addr_q.size()) begin
            check("evict_addr", wb_addr_q[w0 + b], 64'h1000 + 64'(b) * 8);
            check("evict_data", wb_data_q[w0 + b], (b == 2) ? 64'hAAAA : 64'h10 + 64'(b));
          end
        end
      end
      if (i == 11) begin
        for (int b = 0; b < WPL; b++) begin
          if (w0 + b < wb_addr_q.size()) begin
            check("thr_evict_addr", wb_addr_q[w0 + b], 64'h5000 + 64'(b) * 8);
            check("thr_evict_data", wb_data_q[w0 + b], (b == 3) ? 64'h1234 : 64'h50 + 64'(b));
          end
        end
      end
    end
    throttle = 0;

    // Reset while the 4th fill beat is on the bus
    @(negedge clk);
    core_reqcyc = 1'b1;
    core_req    = 64'h8000;
    core_we     = 1'b0;
    hit4 = 0;
    for (int i = 0; i < 100 && !hit4; i++) begin
      @(negedge clk);
      #1;
      if (core_reqack) core_reqcyc = 1'b0;
      if (mem_respcyc && fill_idx == 4) hit4 = 1;
    end
    check("reached_4th_beat", 64'(hit4), 64'd1);
    check("respack_in_fill", 64'(mem_respack), 64'(mem_respcyc));
    core_reqcyc = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midfill_rst_mem_reqcyc", 64'(mem_reqcyc), 64'd0);
    check("midfill_rst_respack", 64'(mem_respack), 64'd0);
    check("midfill_rst_respcyc", 64'(core_respcyc), 64'd0);
    check("midfill_rst_reqack", 64'(core_reqack), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv = '{64'h8008, 1'b0, 64'h0, 64'h81, 1, 0, 12, 0, 0};
    access(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
